// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC ownership, one-cycle memory latency tracking, 2-entry
// decode buffer, redirect squash and halt drain. Define FETCH_PERF_EN for perf counters.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_RUN  | issuing fetches whenever buffer space allows
// ST_HALT | no new fetches; in-flight data lands, buffer drains
module fetch_controller #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = {{(PC_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] out_pc,
    input  logic [31:0]         in_inst,
    input  logic                in_redirect,
    input  logic [PC_WIDTH-1:0] in_redirect_pc,
    input  logic                in_halt,
    output logic                out_valid,
    output logic [31:0]         out_inst,
    output logic [PC_WIDTH-1:0] out_inst_pc,
    input  logic                in_ready,
    output logic                out_idle,
    output logic [31:0]         out_fetch_cnt,
    output logic [31:0]         out_squash_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic                inflight_q;
    logic [PC_WIDTH-1:0] tag_q;
    logic [31:0]         e1_inst_q;
    logic [PC_WIDTH-1:0] e1_pc_q;
    logic [2:0]          occupancy;
    logic                issue;
    logic                pop;
    logic                push;

    assign pop       = out_valid && in_ready;
    assign push      = inflight_q && !in_redirect;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (in_halt)  state_d = ST_HALT;
            ST_HALT: if (!in_halt) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // A slot freed by this cycle's pop can be refilled by a fetch issued now.
    always_comb begin
        issue    = 1'b0;
        out_idle = 1'b0;
        case (state_q)
            ST_RUN:  issue    = !in_halt && ((occupancy < 3'd2) || (occupancy == 3'd2 && pop));
            ST_HALT: out_idle = (count_q == 2'd0) && !inflight_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc     <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= issue && !in_redirect;
            if (in_redirect) begin
                out_pc <= in_redirect_pc;
            end else if (issue) begin
                out_pc <= out_pc + PC_STEP;
            end
            if (issue) begin
                tag_q <= out_pc;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (in_redirect) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_inst_pc <= '0;
            e1_inst_q   <= '0;
            e1_pc_q     <= '0;
        end else begin
            count_q   <= count_d;
            out_valid <= (count_d != 2'd0);
            if (!in_redirect) begin
                if (pop) begin
                    if (count_q == 2'd2) begin
                        out_inst    <= e1_inst_q;
                        out_inst_pc <= e1_pc_q;
                        if (push) begin
                            e1_inst_q <= in_inst;
                            e1_pc_q   <= tag_q;
                        end
                    end else if (push) begin
                        out_inst    <= in_inst;
                        out_inst_pc <= tag_q;
                    end
                end else if (push) begin
                    if (count_q == 2'd0) begin
                        out_inst    <= in_inst;
                        out_inst_pc <= tag_q;
                    end else begin
                        e1_inst_q <= in_inst;
                        e1_pc_q   <= tag_q;
                    end
                end
            end
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == 2'd2));

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] squash_cnt_q;
    logic [1:0]  flushed;
    logic [2:0]  squash_inc;

    // The head popped during a redirect is delivered, not flushed.
    assign flushed    = count_q - {1'b0, pop};
    assign squash_inc = {1'b0, flushed} + {2'b00, inflight_q} + {2'b00, issue};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (in_redirect) begin
                squash_cnt_q <= squash_cnt_q + {29'd0, squash_inc};
            end
        end
    end

    assign out_fetch_cnt  = fetch_cnt_q;
    assign out_squash_cnt = squash_cnt_q;
`else
    assign out_fetch_cnt  = '0;
    assign out_squash_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed timing scenarios plus randomized ready/redirect/halt
// traffic, with a program-order scoreboard checking every delivered instruction.
module tb_fetch_controller;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] out_pc;
    logic [31:0] in_inst;
    logic        in_redirect;
    logic [31:0] in_redirect_pc;
    logic        in_halt;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_inst_pc;
    logic        in_ready;
    logic        out_idle;
    logic [31:0] out_fetch_cnt;
    logic [31:0] out_squash_cnt;

    // narrow-PC instance, free running, used to observe address wrap
    logic [3:0]  out_pc4;
    logic [31:0] in_inst4;
    logic        in_redirect4 = 1'b0;
    logic [3:0]  in_redirect_pc4 = 4'd0;
    logic        in_halt4 = 1'b0;
    logic        out_valid4;
    logic [31:0] out_inst4;
    logic [3:0]  out_inst_pc4;
    logic        in_ready4 = 1'b1;
    logic        out_idle4;
    logic [31:0] out_fetch_cnt4;
    logic [31:0] out_squash_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_controller #(.PC_WIDTH(32), .RESET_PC(32'd0), .PC_STEP(32'd1)) dut (
        .clk(clk), .rst_n(rst_n), .out_pc(out_pc), .in_inst(in_inst),
        .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc), .in_halt(in_halt),
        .out_valid(out_valid), .out_inst(out_inst), .out_inst_pc(out_inst_pc),
        .in_ready(in_ready), .out_idle(out_idle),
        .out_fetch_cnt(out_fetch_cnt), .out_squash_cnt(out_squash_cnt)
    );

    fetch_controller #(.PC_WIDTH(4), .RESET_PC(4'd14), .PC_STEP(4'd1)) dut4 (
        .clk(clk), .rst_n(rst_n), .out_pc(out_pc4), .in_inst(in_inst4),
        .in_redirect(in_redirect4), .in_redirect_pc(in_redirect_pc4), .in_halt(in_halt4),
        .out_valid(out_valid4), .out_inst(out_inst4), .out_inst_pc(out_inst_pc4),
        .in_ready(in_ready4), .out_idle(out_idle4),
        .out_fetch_cnt(out_fetch_cnt4), .out_squash_cnt(out_squash_cnt4)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA0 + pc;
    endfunction

    function automatic logic [31:0] perf(input logic [31:0] v);
        return PERF ? v : 32'd0;
    endfunction

    // synchronous-read instruction memories
    always @(posedge clk) in_inst  <= inst_of(out_pc);
    always @(posedge clk) in_inst4 <= inst_of({28'd0, out_pc4});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream starts (reset PC, redirect targets) queued by the driver, consumed by the monitor.
    logic [31:0] seg_q[$];
    logic [31:0] cur_pc;
    bit          have_seg;
    int          delivered;
    int          total_delivered = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_seg  = 1'b0;
            delivered = 0;
        end else begin
            if (!have_seg && seg_q.size() > 0) begin
                cur_pc   = seg_q.pop_front();
                have_seg = 1'b1;
            end
            if (out_valid && in_ready) begin
                chk("fetch_cnt", out_fetch_cnt, perf(32'(delivered)));
                if (!have_seg) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream: delivered pc 0x%0h, expected nothing", out_inst_pc);
                end else begin
                    chk("stream_pc", out_inst_pc, cur_pc);
                    chk("stream_inst", out_inst, inst_of(cur_pc));
                end
                cur_pc = cur_pc + 32'd1;
                delivered++;
                total_delivered++;
            end
            if (in_redirect) begin
                if (seg_q.size() > 0) begin
                    cur_pc   = seg_q.pop_front();
                    have_seg = 1'b1;
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL redirect: got no queued target, expected one");
                end
            end
        end
    end

    logic [3:0] exp4;
    int         n4 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp4 = 4'd14;
        end else if (out_valid4) begin
            chk("wrap_pc", {28'd0, out_inst_pc4}, {28'd0, exp4});
            chk("wrap_inst", out_inst4, inst_of({28'd0, exp4}));
            exp4 = exp4 + 4'd1;
            n4++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: reset released just before the first fetch edge.
    task automatic do_reset();
        rst_n          = 1'b0;
        in_ready       = 1'b0;
        in_redirect    = 1'b0;
        in_redirect_pc = 32'd0;
        in_halt        = 1'b0;
        seg_q.delete();
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_inst_pc", out_inst_pc, 32'd0);
        chk("rst_idle", {31'd0, out_idle}, 32'd0);
        chk("rst_fetch_cnt", out_fetch_cnt, 32'd0);
        chk("rst_squash_cnt", out_squash_cnt, 32'd0);
        rst_n = 1'b1;
        seg_q.push_back(32'd0);
    endtask

    task automatic redir(input logic [31:0] target);
        in_redirect    = 1'b1;
        in_redirect_pc = target;
        seg_q.push_back(target);
    endtask

    initial begin
        int w;

        // streaming from reset
        do_reset();
        in_ready = 1'b1;
        step();
        chk("c1_valid", {31'd0, out_valid}, 32'd0);
        chk("c1_pc", out_pc, 32'd1);
        step();
        chk("c2_valid", {31'd0, out_valid}, 32'd1);
        chk("c2_inst", out_inst, 32'hA0);
        chk("c2_inst_pc", out_inst_pc, 32'd0);
        for (int c = 3; c < 10; c++) begin
            step();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_seq_pc", out_inst_pc, 32'(c - 2));
        end

        // backpressure: words 0 and 1 buffered, so the next fetch address sits at 2
        do_reset();
        in_ready = 1'b1;
        step();
        step();
        in_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_head_pc", out_inst_pc, 32'd0);
            chk("stall_head_inst", out_inst, 32'hA0);
            chk("stall_out_pc", out_pc, 32'd2);
            step();
        end
        in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("release_valid", {31'd0, out_valid}, 32'd1);
            chk("release_pc", out_inst_pc, 32'(i));
            step();
        end

        // redirect with head popped, second entry flushed and the fetch of pc 2 squashed
        do_reset();
        in_ready = 1'b1;
        step();
        step();
        in_ready = 1'b0;
        repeat (5) step();
        in_ready = 1'b1;
        redir(32'd8);
        chk("redir_head_pc", out_inst_pc, 32'd0);
        step();
        in_redirect = 1'b0;
        chk("redir_k1_pc", out_pc, 32'd8);
        chk("redir_k1_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_squash_cnt", out_squash_cnt, perf(32'd2));
        chk("redir_fetch_cnt", out_fetch_cnt, perf(32'd1));
        step();
        chk("redir_k2_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("redir_k3_valid", {31'd0, out_valid}, 32'd1);
        chk("redir_k3_inst_pc", out_inst_pc, 32'd8);
        chk("redir_k3_inst", out_inst, 32'hA8);

        // halt mid-stream, drain, resume at the next sequential pc
        do_reset();
        in_ready = 1'b1;
        repeat (6) step();
        in_halt = 1'b1;
        step();
        chk("halt_c7_idle", {31'd0, out_idle}, 32'd0);
        chk("halt_c7_inst_pc", out_inst_pc, 32'd5);
        step();
        chk("halt_c8_idle", {31'd0, out_idle}, 32'd1);
        chk("halt_c8_valid", {31'd0, out_valid}, 32'd0);
        chk("halt_c8_pc", out_pc, 32'd6);
        repeat (3) step();
        chk("halt_hold_idle", {31'd0, out_idle}, 32'd1);
        chk("halt_hold_pc", out_pc, 32'd6);
        in_halt = 1'b0;
        step();
        chk("resume_idle", {31'd0, out_idle}, 32'd0);
        chk("resume_pc", out_pc, 32'd6);
        step();
        step();
        chk("resume_valid", {31'd0, out_valid}, 32'd1);
        chk("resume_inst_pc", out_inst_pc, 32'd6);

        // asynchronous reset with two words buffered
        do_reset();
        in_ready = 1'b1;
        step();
        step();
        in_ready = 1'b0;
        step();
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_pc", out_pc, 32'd0);
        chk("async_rst_inst_pc", out_inst_pc, 32'd0);
        do_reset();
        in_ready = 1'b1;
        step();
        step();
        chk("restart_valid", {31'd0, out_valid}, 32'd1);
        chk("restart_inst_pc", out_inst_pc, 32'd0);

        // randomized traffic, including redirects just below the 32-bit wrap
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_ready    = ($urandom_range(0, 3) != 0);
            in_redirect = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    redir(32'($urandom_range(0, 64)));
                else
                    redir(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 29) == 0) in_halt = ~in_halt;
            step();
        end
        in_redirect = 1'b0;
        in_halt     = 1'b1;
        in_ready    = 1'b1;
        w = 0;
        while (!out_idle && w < 20) begin
            step();
            w++;
        end
        chk("final_idle", {31'd0, out_idle}, 32'd1);
        chk("final_fetch_cnt", out_fetch_cnt, perf(32'(delivered)));
        chk("random_liveness", {31'd0, (total_delivered > 300)}, 32'd1);
        chk("wrap_liveness", {31'd0, (n4 > 16)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
